mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - memory-access type encodings and arbiter state encodings
package mem_arbiter_pkg;

  localparam logic [1:0] ACC_WORD  = 2'd0;
  localparam logic [1:0] ACC_DWORD = 2'd1;
  localparam logic [1:0] ACC_BURST = 2'd2;

  localparam logic [1:0] MA_STATE_IDLE  = 2'd0;
  localparam logic [1:0] MA_STATE_GRANT = 2'd1;
  localparam logic [1:0] MA_STATE_WAIT  = 2'd2;
  localparam logic [1:0] MA_STATE_DONE  = 2'd3;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/DMA arbiter in front of the memory map
// MEM_ARB_ROUND_ROBIN_EN: round-robin on contention; otherwise DMA has fixed priority
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              res_n,

  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [1:0]        cpu_acc,
  input  logic [8:0]        cpu_burst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_din,
  output logic [31:0]       cpu_dout,
  output logic              cpu_ack,

  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [1:0]        dma_acc,
  input  logic [8:0]        dma_burst,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_din,
  output logic [31:0]       dma_dout,
  output logic              dma_ack,

  output logic              mm_cs,
  output logic              mm_wr,
  output logic [1:0]        mm_acc,
  output logic [8:0]        mm_burst,
  output logic [31:0]       mm_addr,
  output logic [31:0]       mm_din,
  output logic              mm_cpu_acc,
  input  logic [31:0]       mm_dout,
  input  logic              mm_ack
);

  logic [1:0]  state_q, state_d;
  logic        mm_cs_q, mm_cs_d;
  logic        mm_wr_q, mm_wr_d;
  logic [1:0]  mm_acc_q, mm_acc_d;
  logic [8:0]  mm_burst_q, mm_burst_d;
  logic [31:0] mm_addr_q, mm_addr_d;
  logic [31:0] mm_din_q, mm_din_d;
  logic        mm_cpu_acc_q, mm_cpu_acc_d;
  logic [31:0] cpu_dout_q, cpu_dout_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [31:0] dma_dout_q, dma_dout_d;
  logic        dma_ack_q, dma_ack_d;
  logic        grant_cpu;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_cpu_q = 1 when the CPU was granted most recently; reset value means DMA
  logic last_cpu_q, last_cpu_d;

  function automatic logic pick_cpu(input logic c_req, input logic d_req, input logic last_cpu);
    if (c_req && d_req) return !last_cpu;
    return c_req;
  endfunction

  assign grant_cpu = pick_cpu(cpu_req, dma_req, last_cpu_q);
`else
  function automatic logic pick_cpu(input logic c_req, input logic d_req);
    return c_req && !d_req;
  endfunction

  assign grant_cpu = pick_cpu(cpu_req, dma_req);
`endif

  always_comb begin
    state_d      = state_q;
    mm_cs_d      = 1'b0;
    mm_wr_d      = mm_wr_q;
    mm_acc_d     = mm_acc_q;
    mm_burst_d   = mm_burst_q;
    mm_addr_d    = mm_addr_q;
    mm_din_d     = mm_din_q;
    mm_cpu_acc_d = mm_cpu_acc_q;
    cpu_dout_d   = cpu_dout_q;
    cpu_ack_d    = 1'b0;
    dma_dout_d   = dma_dout_q;
    dma_ack_d    = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_cpu_d   = last_cpu_q;
`endif

    case (state_q)
      MA_STATE_IDLE: begin
        if (cpu_req || dma_req) begin
          mm_cs_d      = 1'b1;
          mm_cpu_acc_d = grant_cpu;
          mm_wr_d      = grant_cpu ? cpu_wr    : dma_wr;
          mm_acc_d     = grant_cpu ? cpu_acc   : dma_acc;
          mm_burst_d   = grant_cpu ? cpu_burst : dma_burst;
          mm_addr_d    = grant_cpu ? 32'(cpu_addr) : 32'(dma_addr);
          mm_din_d     = grant_cpu ? cpu_din   : dma_din;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_cpu_d   = grant_cpu;
`endif
          state_d      = MA_STATE_GRANT;
        end
      end
      MA_STATE_GRANT: state_d = MA_STATE_WAIT;
      MA_STATE_WAIT: begin
        // No timeout: the memory map is trusted to answer every started access
        if (mm_ack) begin
          if (mm_cpu_acc_q) begin
            cpu_dout_d = mm_dout;
            cpu_ack_d  = 1'b1;
          end else begin
            dma_dout_d = mm_dout;
            dma_ack_d  = 1'b1;
          end
          state_d = MA_STATE_DONE;
        end
      end
      MA_STATE_DONE: state_d = MA_STATE_IDLE;
      default:       state_d = MA_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q      <= MA_STATE_IDLE;
      mm_cs_q      <= 1'b0;
      mm_wr_q      <= 1'b0;
      mm_acc_q     <= 2'd0;
      mm_burst_q   <= 9'd0;
      mm_addr_q    <= 32'd0;
      mm_din_q     <= 32'd0;
      mm_cpu_acc_q <= 1'b0;
      cpu_dout_q   <= 32'd0;
      cpu_ack_q    <= 1'b0;
      dma_dout_q   <= 32'd0;
      dma_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mm_cs_q      <= mm_cs_d;
      mm_wr_q      <= mm_wr_d;
      mm_acc_q     <= mm_acc_d;
      mm_burst_q   <= mm_burst_d;
      mm_addr_q    <= mm_addr_d;
      mm_din_q     <= mm_din_d;
      mm_cpu_acc_q <= mm_cpu_acc_d;
      cpu_dout_q   <= cpu_dout_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_dout_q   <= dma_dout_d;
      dma_ack_q    <= dma_ack_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) last_cpu_q <= 1'b0;
    else        last_cpu_q <= last_cpu_d;
  end
`endif

  assign mm_cs      = mm_cs_q;
  assign mm_wr      = mm_wr_q;
  assign mm_acc     = mm_acc_q;
  assign mm_burst   = mm_burst_q;
  assign mm_addr    = mm_addr_q;
  assign mm_din     = mm_din_q;
  assign mm_cpu_acc = mm_cpu_acc_q;
  assign cpu_dout   = cpu_dout_q;
  assign cpu_ack    = cpu_ack_q;
  assign dma_dout   = dma_dout_q;
  assign dma_ack    = dma_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed-vector bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W = 24;

  logic              clk;
  logic              res_n;
  logic              cpu_req, cpu_wr, cpu_ack;
  logic [1:0]        cpu_acc;
  logic [8:0]        cpu_burst;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_din, cpu_dout;
  logic              dma_req, dma_wr, dma_ack;
  logic [1:0]        dma_acc;
  logic [8:0]        dma_burst;
  logic [ADDR_W-1:0] dma_addr;
  logic [31:0]       dma_din, dma_dout;
  logic              mm_cs, mm_wr, mm_cpu_acc, mm_ack;
  logic [1:0]        mm_acc;
  logic [8:0]        mm_burst;
  logic [31:0]       mm_addr, mm_din, mm_dout;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .res_n(res_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_acc(cpu_acc), .cpu_burst(cpu_burst),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_acc(dma_acc), .dma_burst(dma_burst),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_dout(dma_dout), .dma_ack(dma_ack),
    .mm_cs(mm_cs), .mm_wr(mm_wr), .mm_acc(mm_acc), .mm_burst(mm_burst),
    .mm_addr(mm_addr), .mm_din(mm_din), .mm_cpu_acc(mm_cpu_acc),
    .mm_dout(mm_dout), .mm_ack(mm_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    tick();
    res_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({mm_cs, mm_wr, mm_cpu_acc, cpu_ack, dma_ack} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got cs/wr/cpu_acc/cpu_ack/dma_ack=%b required 00000",
               {mm_cs, mm_wr, mm_cpu_acc, cpu_ack, dma_ack});
    end
    vectors++;
    if (mm_addr !== 32'd0 || mm_din !== 32'd0 || mm_burst !== 9'd0 || mm_acc !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_mm: got addr=%h din=%h burst=%0d acc=%0d required all zero",
               mm_addr, mm_din, mm_burst, mm_acc);
    end
    vectors++;
    if (cpu_dout !== 32'd0 || dma_dout !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_dout: got cpu_dout=%h dma_dout=%h required 0", cpu_dout, dma_dout);
    end
    res_n = 1'b1;
    tick();
  endtask

  task automatic test_dma_burst();
    int cs_count = 0;
    int ack_count = 0;
    dma_req = 1'b1; dma_wr = 1'b1; dma_acc = ACC_BURST; dma_burst = 9'd255;
    dma_addr = 24'h001000; dma_din = 32'hA5A50001;
    tick();
    if (mm_cs) cs_count++;
    vectors++;
    if (mm_cs !== 1'b1 || mm_cpu_acc !== 1'b0 || mm_wr !== 1'b1 || mm_acc !== ACC_BURST) begin
      miscompares++;
      $display("FAIL dma_grant: got cs=%b cpu_acc=%b wr=%b acc=%0d required 1 0 1 %0d",
               mm_cs, mm_cpu_acc, mm_wr, mm_acc, ACC_BURST);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mm_cs) cs_count++;
      if (dma_ack) ack_count++;
      vectors++;
      if (mm_burst !== 9'd255 || mm_addr !== 32'h00001000 || mm_din !== 32'hA5A50001 ||
          mm_wr !== 1'b1 || mm_cpu_acc !== 1'b0) begin
        miscompares++;
        $display("FAIL dma_stable cycle %0d: got burst=%0d addr=%h din=%h wr=%b cpu_acc=%b required 255 00001000 a5a50001 1 0",
                 i, mm_burst, mm_addr, mm_din, mm_wr, mm_cpu_acc);
      end
    end
    mm_ack = 1'b1; mm_dout = 32'h12345678;
    tick();
    mm_ack = 1'b0;
    if (mm_cs) cs_count++;
    if (dma_ack) ack_count++;
    vectors++;
    if (dma_ack !== 1'b1 || cpu_ack !== 1'b0 || dma_dout !== 32'h12345678) begin
      miscompares++;
      $display("FAIL dma_done: got dma_ack=%b cpu_ack=%b dma_dout=%h required 1 0 12345678",
               dma_ack, cpu_ack, dma_dout);
    end
    vectors++;
    if (mm_burst !== 9'd255 || mm_addr !== 32'h00001000 || mm_cpu_acc !== 1'b0) begin
      miscompares++;
      $display("FAIL dma_done_stable: got burst=%0d addr=%h cpu_acc=%b required 255 00001000 0",
               mm_burst, mm_addr, mm_cpu_acc);
    end
    dma_req = 1'b0;
    tick();
    if (dma_ack) ack_count++;
    vectors++;
    if (cs_count !== 1 || ack_count !== 1) begin
      miscompares++;
      $display("FAIL dma_pulses: got cs_count=%0d ack_count=%0d required 1 1", cs_count, ack_count);
    end
  endtask

  task automatic test_cpu_read();
    int cs_count = 0;
    int ack_count = 0;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_acc = ACC_DWORD; cpu_burst = 9'd0;
    cpu_addr = 24'h000100; cpu_din = 32'h0;
    tick();
    if (mm_cs) cs_count++;
    vectors++;
    if (mm_cs !== 1'b1 || mm_cpu_acc !== 1'b1 || mm_addr !== 32'h00000100 ||
        mm_wr !== 1'b0 || mm_acc !== ACC_DWORD) begin
      miscompares++;
      $display("FAIL cpu_grant: got cs=%b cpu_acc=%b addr=%h wr=%b acc=%0d required 1 1 00000100 0 %0d",
               mm_cs, mm_cpu_acc, mm_addr, mm_wr, mm_acc, ACC_DWORD);
    end
    // an ack arriving while still in GRANT must be ignored
    mm_ack = 1'b1; mm_dout = 32'h0BAD0BAD;
    tick();
    mm_ack = 1'b0;
    if (mm_cs) cs_count++;
    vectors++;
    if (cpu_ack !== 1'b0 || cpu_dout !== 32'h0) begin
      miscompares++;
      $display("FAIL cpu_grant_ack_ignored: got cpu_ack=%b cpu_dout=%h required 0 00000000",
               cpu_ack, cpu_dout);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      if (mm_cs) cs_count++;
      if (cpu_ack) ack_count++;
    end
    mm_ack = 1'b1; mm_dout = 32'hDEADBEEF;
    tick();
    mm_ack = 1'b0;
    if (cpu_ack) ack_count++;
    vectors++;
    if (cpu_ack !== 1'b1 || cpu_dout !== 32'hDEADBEEF || dma_ack !== 1'b0 || dma_dout !== 32'h12345678) begin
      miscompares++;
      $display("FAIL cpu_done: got cpu_ack=%b cpu_dout=%h dma_ack=%b dma_dout=%h required 1 deadbeef 0 12345678",
               cpu_ack, cpu_dout, dma_ack, dma_dout);
    end
    cpu_req = 1'b0;
    tick();
    if (cpu_ack) ack_count++;
    vectors++;
    if (cs_count !== 1 || ack_count !== 1 || mm_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL cpu_pulses: got cs_count=%0d ack_count=%0d mm_cs=%b required 1 1 0",
               cs_count, ack_count, mm_cs);
    end
  endtask

  task automatic test_contention();
    logic        exp_cpu;
    logic [31:0] exp_addr;
    logic [31:0] rdata;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_acc = ACC_WORD; cpu_burst = 9'd0;
      cpu_addr = 24'h000200 + 24'(r); cpu_din = 32'h0;
      dma_req = 1'b1; dma_wr = 1'b0; dma_acc = ACC_WORD; dma_burst = 9'd0;
      dma_addr = 24'h000300 + 24'(r); dma_din = 32'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_cpu = 1'b1;
`else
      exp_cpu = 1'b0;
`endif
      for (int k = 0; k < 2; k++) begin
        exp_addr = exp_cpu ? (32'h200 + 32'(r)) : (32'h300 + 32'(r));
        rdata = 32'h10000000 + 32'(r * 2 + k);
        tick();
        vectors++;
        if (mm_cs !== 1'b1 || mm_cpu_acc !== exp_cpu || mm_addr !== exp_addr) begin
          miscompares++;
          $display("FAIL contention_grant r%0d k%0d: got cs=%b cpu_acc=%b addr=%h required 1 %b %h",
                   r, k, mm_cs, mm_cpu_acc, mm_addr, exp_cpu, exp_addr);
        end
        tick();
        mm_ack = 1'b1; mm_dout = rdata;
        tick();
        mm_ack = 1'b0;
        vectors++;
        if ({cpu_ack, dma_ack} !== (exp_cpu ? 2'b10 : 2'b01) ||
            (exp_cpu ? cpu_dout : dma_dout) !== rdata) begin
          miscompares++;
          $display("FAIL contention_done r%0d k%0d: got cpu_ack=%b dma_ack=%b cpu_dout=%h dma_dout=%h required grantee %b data %h",
                   r, k, cpu_ack, dma_ack, cpu_dout, dma_dout, exp_cpu, rdata);
        end
        if (exp_cpu) cpu_req = 1'b0;
        else         dma_req = 1'b0;
        tick();
        vectors++;
        if (mm_cs !== 1'b0 || cpu_ack !== 1'b0 || dma_ack !== 1'b0) begin
          miscompares++;
          $display("FAIL contention_idle r%0d k%0d: got cs=%b cpu_ack=%b dma_ack=%b required 0 0 0",
                   r, k, mm_cs, cpu_ack, dma_ack);
        end
        exp_cpu = !exp_cpu;
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad_acks = 0;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_acc = ACC_DWORD; cpu_addr = 24'h000500;
    tick();
    tick();
    res_n = 1'b0;
    #1;
    vectors++;
    if ({mm_cs, mm_cpu_acc, cpu_ack, dma_ack} !== 4'b0 || mm_addr !== 32'd0 ||
        cpu_dout !== 32'd0 || dma_dout !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got cs=%b cpu_acc=%b acks=%b%b addr=%h cpu_dout=%h dma_dout=%h required all zero",
               mm_cs, mm_cpu_acc, cpu_ack, dma_ack, mm_addr, cpu_dout, dma_dout);
    end
    cpu_req = 1'b0;
    tick();
    res_n = 1'b1;
    tick();
    tick();
    mm_ack = 1'b1; mm_dout = 32'h00000077;
    tick();
    mm_ack = 1'b0;
    if (cpu_ack || dma_ack || mm_cs) bad_acks++;
    tick();
    if (cpu_ack || dma_ack || mm_cs) bad_acks++;
    vectors++;
    if (bad_acks !== 0 || cpu_dout !== 32'd0 || dma_dout !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_stray_ack: got bad_cycles=%0d cpu_dout=%h dma_dout=%h required 0 0 0",
               bad_acks, cpu_dout, dma_dout);
    end
    dma_req = 1'b1; dma_wr = 1'b0; dma_acc = ACC_WORD; dma_burst = 9'd0; dma_addr = 24'h000400;
    tick();
    vectors++;
    if (mm_cs !== 1'b1 || mm_cpu_acc !== 1'b0 || mm_addr !== 32'h00000400) begin
      miscompares++;
      $display("FAIL reset_mid_next_grant: got cs=%b cpu_acc=%b addr=%h required 1 0 00000400",
               mm_cs, mm_cpu_acc, mm_addr);
    end
    tick();
    mm_ack = 1'b1; mm_dout = 32'hCAFEF00D;
    tick();
    mm_ack = 1'b0;
    vectors++;
    if (dma_ack !== 1'b1 || dma_dout !== 32'hCAFEF00D || cpu_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_next_done: got dma_ack=%b dma_dout=%h cpu_ack=%b required 1 cafef00d 0",
               dma_ack, dma_dout, cpu_ack);
    end
    dma_req = 1'b0;
    tick();
  endtask

  task automatic test_idle_ack();
    mm_ack = 1'b1; mm_dout = 32'h55AA55AA;
    tick();
    mm_ack = 1'b0;
    vectors++;
    if (cpu_ack !== 1'b0 || dma_ack !== 1'b0 || mm_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ack_pulse: got cpu_ack=%b dma_ack=%b cs=%b required 0 0 0",
               cpu_ack, dma_ack, mm_cs);
    end
    tick();
    vectors++;
    if (cpu_dout !== 32'd0 || dma_dout !== 32'hCAFEF00D || mm_cs !== 1'b0 || dma_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ack_dout: got cpu_dout=%h dma_dout=%h cs=%b dma_ack=%b required 0 cafef00d 0 0",
               cpu_dout, dma_dout, mm_cs, dma_ack);
    end
  endtask

  initial begin
    res_n = 1'b0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_acc = 2'd0; cpu_burst = 9'd0; cpu_addr = '0; cpu_din = 32'd0;
    dma_req = 1'b0; dma_wr = 1'b0; dma_acc = 2'd0; dma_burst = 9'd0; dma_addr = '0; dma_din = 32'd0;
    mm_ack = 1'b0; mm_dout = 32'd0;
    test_reset();
    test_dma_burst();
    test_cpu_read();
    test_contention();
    test_reset_mid();
    test_idle_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
